// File: rtl/imem_arb_pkg.sv
// ---------------------------------------------------------------------------
// imem_arb_pkg : shared types and constants for the imem port arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package imem_arb_pkg;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LS = 1'b1
  } port_id_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    HOLD   = 2'd2
  } arb_state_e;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/imem_arb_pick.sv
// ---------------------------------------------------------------------------
// imem_arb_pick : 2-way one-hot picker; round-robin on ties with IMEM_ARB_RR_EN
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module imem_arb_pick
  import imem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_e   rr_last,
  output logic [1:0] gnt
);

`ifdef IMEM_ARB_RR_EN
  // On a tie the port that did not win last time goes first.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (rr_last == PORT_IF) ? 2'b10 : 2'b01;
    end
  end
`else
  logic unused_rr_last;
  assign unused_rr_last = rr_last;

  assign gnt = {req[1] & ~req[0], req[0]};
`endif

endmodule

`default_nettype wire

// File: rtl/imem_port_arbiter.sv
// ---------------------------------------------------------------------------
// imem_port_arbiter : shares one synchronous imem between fetch and load ports
// Optional round-robin tie-break: define IMEM_ARB_RR_EN.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int AW     = 32,
  parameter int MEM_AW = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  input  logic          if_rready,
  output logic [31:0]   if_rdata,
  input  logic          ls_req,
  input  logic [AW-1:0] ls_addr,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  input  logic          ls_rready,
  output logic [31:0]   ls_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_stall,
  input  logic [31:0]   mem_rdata
);

  // Only the word address bits the memory decodes are forwarded.
  localparam logic [AW-1:0] ADDR_MASK =
    AW'(((64'd1 << (MEM_AW + 2)) - 64'd1) & ~64'd3);

  arb_state_e    state_q, state_d;
  port_id_e      owner_q, owner_d;
  port_id_e      rr_last;
  logic [31:0]   if_last_q, if_last_d;
  logic [31:0]   ls_last_q, ls_last_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;

  logic          owner_rready;
  logic          grant_ok;
  logic [1:0]    req;
  logic [1:0]    pick_gnt;
  logic [1:0]    gnt;
  logic          gnt_any;
  logic [AW-1:0] sel_addr;

  always_comb begin
    owner_rready = (owner_q == PORT_IF) ? if_rready : ls_rready;
    // A pending response must be taken by its owner before the memory relaunches.
    grant_ok     = (state_q == IDLE) || owner_rready;
    req          = {ls_req, if_req} & {2{grant_ok}};
  end

  imem_arb_pick u_pick (
    .req     (req),
    .rr_last (rr_last),
    .gnt     (pick_gnt)
  );

  assign gnt      = rst ? 2'b00 : pick_gnt;
  assign gnt_any  = |gnt;
  assign sel_addr = (gnt[1] ? ls_addr : if_addr) & ADDR_MASK;

`ifdef IMEM_ARB_RR_EN
  port_id_e rr_last_q, rr_last_d;

  always_comb begin
    rr_last_d = rr_last_q;
    if (gnt_any) begin
      rr_last_d = gnt[1] ? PORT_LS : PORT_IF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_q <= PORT_LS;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

  assign rr_last = rr_last_q;
`else
  assign rr_last = PORT_LS;
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    mem_addr_d = mem_addr_q;
    if_last_d  = if_last_q;
    ls_last_d  = ls_last_q;

    // The last-word registers double as the backpressure hold registers.
    if (state_q == LAUNCH) begin
      if (owner_q == PORT_IF) begin
        if_last_d = mem_rdata;
      end else begin
        ls_last_d = mem_rdata;
      end
    end

    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          state_d = LAUNCH;
        end
      end
      LAUNCH, HOLD: begin
        if (!owner_rready) begin
          state_d = HOLD;
        end else begin
          state_d = gnt_any ? LAUNCH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (gnt_any) begin
      owner_d    = gnt[1] ? PORT_LS : PORT_IF;
      mem_addr_d = sel_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= PORT_IF;
      mem_addr_q <= '0;
      if_last_q  <= NOP_INSN;
      ls_last_q  <= NOP_INSN;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      mem_addr_q <= mem_addr_d;
      if_last_q  <= if_last_d;
      ls_last_q  <= ls_last_d;
    end
  end

  always_comb begin
    if_gnt    = gnt[0];
    ls_gnt    = gnt[1];
    mem_stall = ~gnt_any & ~rst;
    mem_addr  = gnt_any ? sel_addr : mem_addr_q;
    if_rvalid = (state_q != IDLE) && (owner_q == PORT_IF);
    ls_rvalid = (state_q != IDLE) && (owner_q == PORT_LS);
    if_rdata  = ((state_q == LAUNCH) && (owner_q == PORT_IF)) ? mem_rdata : if_last_q;
    ls_rdata  = ((state_q == LAUNCH) && (owner_q == PORT_LS)) ? mem_rdata : ls_last_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imem_port_arbiter : directed + random bench against a transaction model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_imem_port_arbiter;

  localparam int AW     = 32;
  localparam int MEM_AW = 15;
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] ADDR_MASK = 32'(((64'd1 << (MEM_AW + 2)) - 64'd1) & ~64'd3);
`ifdef IMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0, ls_req = 1'b0;
  logic [AW-1:0] if_addr = '0, ls_addr = '0;
  logic          if_rready = 1'b1, ls_rready = 1'b1;
  logic          if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_stall;
  logic [31:0]   if_rdata, ls_rdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  imem_port_arbiter #(.AW(AW), .MEM_AW(MEM_AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rready (if_rready),
    .if_rdata  (if_rdata),
    .ls_req    (ls_req),
    .ls_addr   (ls_addr),
    .ls_gnt    (ls_gnt),
    .ls_rvalid (ls_rvalid),
    .ls_rready (ls_rready),
    .ls_rdata  (ls_rdata),
    .mem_addr  (mem_addr),
    .mem_stall (mem_stall),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = (a >> 2) & ((32'd1 << MEM_AW) - 32'd1);
    return 32'h5A5A_0000 ^ (w * 32'h0100_0193) ^ (w << 16);
  endfunction

  // Synchronous memory: latches the address when not stalled.
  logic [31:0] mem_lat = '0;
  always @(posedge clk) if (!mem_stall) mem_lat <= mem_addr;
  assign mem_rdata = mem_word(mem_lat);

  // Transaction model: at most one response outstanding, owned by one port.
  bit          m_out;
  int          m_own;
  logic [31:0] m_data;
  logic [31:0] m_last [2];
  logic [31:0] m_addr;
  int          m_rr;

  task automatic model_reset();
    m_out     = 1'b0;
    m_own     = 0;
    m_data    = '0;
    m_last[0] = NOP;
    m_last[1] = NOP;
    m_addr    = '0;
    m_rr      = 1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_if_gnt",    32'(if_gnt),    32'd0);
    check_eq("rst_ls_gnt",    32'(ls_gnt),    32'd0);
    check_eq("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    check_eq("rst_ls_rvalid", 32'(ls_rvalid), 32'd0);
    check_eq("rst_if_rdata",  if_rdata,       NOP);
    check_eq("rst_ls_rdata",  ls_rdata,       NOP);
    check_eq("rst_mem_stall", 32'(mem_stall), 32'd0);
    check_eq("rst_mem_addr",  mem_addr,       32'd0);
  endtask

  // One clock cycle: drive, compare mid-cycle against the model, advance model.
  task automatic step(input logic ir, input logic [31:0] ia,
                      input logic lr, input logic [31:0] la,
                      input logic irr, input logic lrr, output int win);
    logic        own_ready;
    logic [31:0] ea;
    @(posedge clk);
    #1;
    if_req = ir; if_addr = ia; ls_req = lr; ls_addr = la;
    if_rready = irr; ls_rready = lrr;
    @(negedge clk);
    own_ready = (m_own == 0) ? irr : lrr;
    win = -1;
    if (!m_out || own_ready) begin
      if (ir && lr) win = RR ? ((m_rr == 0) ? 1 : 0) : 0;
      else if (ir)  win = 0;
      else if (lr)  win = 1;
    end
    ea = (win == 0) ? (ia & ADDR_MASK) : (win == 1) ? (la & ADDR_MASK) : m_addr;
    check_eq("if_gnt",    32'(if_gnt),    32'(win == 0));
    check_eq("ls_gnt",    32'(ls_gnt),    32'(win == 1));
    check_eq("mem_stall", 32'(mem_stall), 32'(win < 0));
    check_eq("mem_addr",  mem_addr,       ea);
    check_eq("if_rvalid", 32'(if_rvalid), 32'(m_out && m_own == 0));
    check_eq("ls_rvalid", 32'(ls_rvalid), 32'(m_out && m_own == 1));
    check_eq("if_rdata",  if_rdata, (m_out && m_own == 0) ? m_data : m_last[0]);
    check_eq("ls_rdata",  ls_rdata, (m_out && m_own == 1) ? m_data : m_last[1]);
    if (m_out && own_ready) begin
      m_last[m_own] = m_data;
      m_out = 1'b0;
    end
    if (win >= 0) begin
      m_out  = 1'b1;
      m_own  = win;
      m_data = mem_word(ea);
      m_addr = ea;
      m_rr   = win;
    end
  endtask

  task automatic reset_mid();
    @(posedge clk);
    #2;
    rst = 1'b1;
    if_req = 1'b0; ls_req = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    logic        ir, lr, irr, lrr;
    logic [31:0] ia, la;

    model_reset();
    #1 rst = 1'b1;
    #6;
    check_reset_outputs();
    @(posedge clk);
    #1 rst = 1'b0;

    // Fetch stream of four words, then drain.
    for (int k = 0; k < 4; k++) step(1'b1, 32'(4 * k), 1'b0, 32'h0, 1'b1, 1'b1, w);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, w);

    // Contention with requests held until granted.
    ir = 1'b1; lr = 1'b1; ia = 32'h10; la = 32'h200;
    for (int k = 0; k < 3; k++) begin
      step(ir, ia, lr, la, 1'b1, 1'b1, w);
      if (w == 0) ir = 1'b0;
      if (w == 1) lr = 1'b0;
    end

    // Both ports requesting continuously for four cycles.
    ia = 32'h400; la = 32'h800;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, ia, 1'b1, la, 1'b1, 1'b1, w);
      if (w == 0) ia = ia + 32'h4;
      if (w == 1) la = la + 32'h4;
    end
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, w);

    // Backpressure on the load port while fetch waits.
    step(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b1, w);
    for (int k = 0; k < 3; k++) step(1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 1'b0, w);
    step(1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 1'b1, w);

    // Idle gap.
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, w);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, w);

    // Reset with a response in flight.
    step(1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 1'b1, w);
    reset_mid();
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, w);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, w);

    // Random traffic honouring the hold-until-granted request rule.
    ir = 1'b0; lr = 1'b0; ia = '0; la = '0; w = -1;
    for (int c = 0; c < 400; c++) begin
      if (!(ir && w != 0)) begin
        ir = ($urandom_range(0, 99) < 65);
        ia = $urandom;
      end
      if (!(lr && w != 1)) begin
        lr = ($urandom_range(0, 99) < 50);
        la = $urandom;
      end
      irr = ($urandom_range(0, 3) != 0);
      lrr = ($urandom_range(0, 3) != 0);
      step(ir, ia, lr, la, irr, lrr, w);
      if (c == 200) begin
        reset_mid();
        ir = 1'b0; lr = 1'b0; w = -1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
